// File: rtl/matrix_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : matrix_loader                                                |
// | Description : Packs a serial stream of signed 3x3 matrix elements into one |
// |               row-major word; holding register for one waiting matrix.     |
// |               Optional macro MATRIX_LOADER_TRANSPOSE_EN: column-major input.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module matrix_loader #(
  parameter  int ELEM_W = 4,
  localparam int MAT_W  = 9 * ELEM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MAT_W-1:0]  out_data,
  output logic [7:0]        mat_count
);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_count, w_count_nxt;
  logic [MAT_W-1:0]   r_asm, w_asm_nxt;
  logic [MAT_W-1:0]   r_out_data, w_out_data_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic [7:0]         r_mat_count, w_mat_count_nxt;
  logic [3:0]         w_idx;
  logic [MAT_W-1:0]   w_asm_new;
  logic               w_accept;
  logic               w_xfer;

  assign in_ready  = (r_state == S_FILL) && !in_abort;
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = r_out_valid && out_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign mat_count = r_mat_count;

  // Row-major slot index for the element arriving at position r_count
  always_comb begin
`ifdef MATRIX_LOADER_TRANSPOSE_EN
    case (r_count)
      4'd0:    w_idx = 4'd0;
      4'd1:    w_idx = 4'd3;
      4'd2:    w_idx = 4'd6;
      4'd3:    w_idx = 4'd1;
      4'd4:    w_idx = 4'd4;
      4'd5:    w_idx = 4'd7;
      4'd6:    w_idx = 4'd2;
      4'd7:    w_idx = 4'd5;
      4'd8:    w_idx = 4'd8;
      default: w_idx = 4'd0;
    endcase
`else
    w_idx = r_count;
`endif
  end

  always_comb begin
    w_asm_new = r_asm;
    for (int i = 0; i < 9; i++) begin
      if (w_idx == 4'(i)) begin
        w_asm_new[MAT_W-1-i*ELEM_W -: ELEM_W] = in_data;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_asm_nxt       = r_asm;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_mat_count_nxt = r_mat_count;

    if (w_xfer) begin
      w_out_valid_nxt = 1'b0;
      w_mat_count_nxt = r_mat_count + 8'd1;
    end

    case (r_state)
      S_FILL: begin
        if (in_abort) begin
          w_count_nxt = 4'd0;
        end else if (w_accept) begin
          if (r_count == 4'd8) begin
            w_count_nxt = 4'd0;
            if (!r_out_valid || out_ready) begin
              w_out_data_nxt  = w_asm_new;
              w_out_valid_nxt = 1'b1;
            end else begin
              w_asm_nxt   = w_asm_new;
              w_state_nxt = S_FULL;
            end
          end else begin
            w_asm_nxt   = w_asm_new;
            w_count_nxt = r_count + 4'd1;
          end
        end
      end
      S_FULL: begin
        // Abort discards the held word even if the output transfers this cycle
        if (in_abort) begin
          w_state_nxt = S_FILL;
          w_count_nxt = 4'd0;
        end else if (out_ready) begin
          w_out_data_nxt  = r_asm;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_FILL;
          w_count_nxt     = 4'd0;
        end
      end
      default: begin
        w_state_nxt = S_FILL;
        w_count_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FILL;
      r_count     <= 4'd0;
      r_asm       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_mat_count <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_asm       <= w_asm_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_mat_count <= w_mat_count_nxt;
    end
  end

endmodule
`default_nettype wire
